// File: rtl/mem_arbiter_if.sv
// Requester/memory side signals of the node-memory arbiter.
// The arbiter uses the slave view; the requester/memory environment drives the master view.
interface mem_arbiter_if #(
   parameter int MEM_WIDTH = 8
);
   logic [7:0]           req;
   logic [7:0]           rd;
   logic [7:0]           wr;
   logic [7:0]           gnt;
   logic [2:0]           select;
   logic                 mem_re;
   logic                 mem_we;
   logic [MEM_WIDTH-1:0] mem_rdata;
   logic [MEM_WIDTH-1:0] rdata;
   logic [7:0]           rvalid;
   logic                 timeout;

   modport master (
      output req, rd, wr, mem_rdata,
      input  gnt, select, mem_re, mem_we, rdata, rvalid, timeout
   );

   modport slave (
      input  req, rd, wr, mem_rdata,
      output gnt, select, mem_re, mem_we, rdata, rvalid, timeout
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter for the 8 blocks sharing the node memory, with tagged read-return routing.
// Optional owner watchdog is compiled in when ARB_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no owner; next requester after ptr is granted
// GRANT | one owner; its strobes are forwarded to memory
// DRAIN | owner released; waiting for its reads to come back
module mem_arbiter #(
   parameter int WORD_WIDTH = 16,
   parameter int MEM_WIDTH  = 8,
   parameter int RD_LATENCY = 2
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   if (WORD_WIDTH < 1 || RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_param_check
      $error("mem_arbiter: RD_LATENCY must be 1..4 and WORD_WIDTH positive");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [7:0]           gnt_q, gnt_d;
   logic [2:0]           sel_q, sel_d;
   logic [2:0]           ptr_q, ptr_d;

   logic                 pick_hit;
   logic [2:0]           pick_idx;
   logic [2:0]           cand;

   logic                 owner_live_raw;
   logic                 owner_live;
   logic                 force_rel;
   logic                 mem_re_c;
   logic                 mem_we_c;

   logic [RD_LATENCY-1:0] pipe_vld;
   logic [2:0]            pipe_tag [RD_LATENCY];
   logic [2:0]            inflight;
   logic [MEM_WIDTH-1:0]  rdata_q;
   logic [7:0]            rvalid_q;

   // First requesting index strictly after ptr, wrapping; ptr itself is checked last.
   always_comb begin
      pick_hit = 1'b0;
      pick_idx = ptr_q;
      cand     = '0;
      for (int k = 1; k <= 8; k++) begin
         cand = ptr_q + 3'(k);
         if (!pick_hit && bus.req[cand]) begin
            pick_hit = 1'b1;
            pick_idx = cand;
         end
      end
   end

   always_comb begin
      inflight = '0;
      for (int k = 0; k < RD_LATENCY; k++) begin
         inflight = inflight + {2'b00, pipe_vld[k]};
      end
   end

   assign owner_live_raw = (state_q == S_GRANT) && gnt_q[sel_q] && bus.req[sel_q];
   assign owner_live     = owner_live_raw && !force_rel;
   assign mem_re_c       = owner_live && bus.rd[sel_q];
   assign mem_we_c       = owner_live && bus.wr[sel_q] && !bus.rd[sel_q];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         gnt_q   <= '0;
         sel_q   <= '0;
         ptr_q   <= 3'd7;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            gnt_d = '0;
            if (pick_hit) begin
               gnt_d   = 8'd1 << pick_idx;
               sel_d   = pick_idx;
               state_d = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!bus.req[sel_q] || force_rel) begin
               gnt_d   = '0;
               ptr_d   = sel_q;
               state_d = (inflight != 3'd0) ? S_DRAIN : S_IDLE;
            end
         end
         S_DRAIN: begin
            gnt_d = '0;
            if (inflight == 3'd0) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            gnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // Each read carries its issuer's tag so the response follows the issuer, not the current owner.
   always_ff @(posedge clk) begin
      if (rst) begin
         pipe_vld <= '0;
         for (int k = 0; k < RD_LATENCY; k++) begin
            pipe_tag[k] <= '0;
         end
         rdata_q  <= '0;
         rvalid_q <= '0;
      end else begin
         pipe_vld[0] <= mem_re_c;
         pipe_tag[0] <= sel_q;
         for (int k = 1; k < RD_LATENCY; k++) begin
            pipe_vld[k] <= pipe_vld[k-1];
            pipe_tag[k] <= pipe_tag[k-1];
         end
         rvalid_q <= pipe_vld[RD_LATENCY-1] ? (8'd1 << pipe_tag[RD_LATENCY-1]) : 8'd0;
         if (pipe_vld[RD_LATENCY-1]) begin
            rdata_q <= bus.mem_rdata;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   logic [7:0] idle_cnt_q;
   logic       timeout_q;
   logic       owner_strobe;

   assign owner_strobe = owner_live_raw && (bus.rd[sel_q] || bus.wr[sel_q]);
   assign force_rel    = (state_q == S_GRANT) && (idle_cnt_q == 8'hFF);

   // Counter only runs while the same owner keeps the grant; any exit restarts it.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         if (state_q == S_GRANT && state_d == S_GRANT) begin
            idle_cnt_q <= owner_strobe ? 8'd0 : idle_cnt_q + 8'd1;
         end else begin
            idle_cnt_q <= '0;
         end
         if (force_rel) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign bus.timeout = timeout_q;
`else
   assign force_rel   = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   assign bus.gnt    = gnt_q;
   assign bus.select = sel_q;
   assign bus.mem_re = mem_re_c;
   assign bus.mem_we = mem_we_c;
   assign bus.rdata  = rdata_q;
   assign bus.rvalid = rvalid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter: a transaction-level model predicts owners,
// strobes and read returns; a separate monitor checks returns against a scoreboard.
module tb_mem_arbiter;
   localparam int RD_LAT = 2;

   localparam logic [7:0] T_RD [4] = '{8'h40, 8'h44, 8'h40, 8'h44};
   localparam logic [7:0] T_WR [4] = '{8'h40, 8'h40, 8'h44, 8'h44};
   localparam logic       T_RE [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
   localparam logic       T_WE [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_arbiter_if #(.MEM_WIDTH(8)) bus ();

   mem_arbiter #(
      .WORD_WIDTH(16),
      .MEM_WIDTH (8),
      .RD_LATENCY(RD_LAT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      logic [2:0] tag;
      logic [7:0] data;
      int         due;
   } exp_t;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t sb[$];
   logic [7:0] memq[$];

   logic [7:0] req_prev  = '0;
   int         owner     = -1;
   int         m_ptr     = 7;
   bit         just_rel  = 1'b0;
   int         starve    = 0;
   int         m_idle    = 0;
   bit         m_to      = 1'b0;
   bit         use_fixed = 1'b0;
   logic [7:0] fixed_val = '0;
   int         rv_count[8];
   int         rv_total  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h at cycle %0d", name, got, want, cyc);
      end
   endtask

   function automatic int rr_next(input int p, input logic [7:0] r);
      for (int k = 1; k <= 8; k++) begin
         if (r[(p + k) % 8]) return (p + k) % 8;
      end
      return -1;
   endfunction

   // Memory + reference model: owner bookkeeping at transaction level, one decision per cycle.
   always @(negedge clk) begin : model
      logic [7:0] d;
      int         exp_i;
      bit         exp_re, exp_we, frc;
      exp_t       e;
      d = use_fixed ? fixed_val : 8'($urandom);
      memq.push_back(d);
      if (memq.size() > RD_LAT) bus.mem_rdata = memq.pop_front();
      if (rst) begin
         sb.delete();
         owner    = -1;
         m_ptr    = 7;
         just_rel = 1'b0;
         starve   = 0;
         m_idle   = 0;
         m_to     = 1'b0;
      end else begin
         check("timeout_flag", {31'b0, bus.timeout}, {31'b0, m_to});
         if (owner >= 0) begin
            check("gnt_hold", {24'b0, bus.gnt}, 32'd1 << owner);
            check("select", {29'b0, bus.select}, owner);
         end else if (bus.gnt != 8'h00) begin
            exp_i = rr_next(m_ptr, req_prev);
            check("handover_gap", {31'b0, just_rel}, 0);
            check("drained_before_grant", sb.size(), 0);
            check("rr_grant", {24'b0, bus.gnt}, (exp_i < 0) ? 32'd0 : (32'd1 << exp_i));
            check("select_on_grant", {29'b0, bus.select}, exp_i);
            owner  = exp_i;
            starve = 0;
            m_idle = 0;
         end else begin
            if (req_prev != 8'h00 && sb.size() == 0) starve++;
            else starve = 0;
            check("grant_starved", starve <= 4, 1);
            if (starve > 4) starve = 0;
         end
         just_rel = 1'b0;
         frc = 1'b0;
`ifdef ARB_TIMEOUT_EN
         if (owner >= 0 && m_idle == 255) frc = 1'b1;
`endif
         exp_re = 1'b0;
         exp_we = 1'b0;
         if (owner >= 0 && bus.req[owner] && !frc) begin
            exp_re = bus.rd[owner];
            exp_we = bus.wr[owner] & ~bus.rd[owner];
         end
         check("mem_strobes", {30'b0, bus.mem_re, bus.mem_we}, {30'b0, exp_re, exp_we});
         if (exp_re) begin
            e.tag  = owner[2:0];
            e.data = d;
            e.due  = cyc + RD_LAT + 1;
            sb.push_back(e);
         end
         if (owner >= 0 && (!bus.req[owner] || frc)) begin
            if (frc) m_to = 1'b1;
            m_ptr    = owner;
            owner    = -1;
            just_rel = 1'b1;
            m_idle   = 0;
         end else if (owner >= 0) begin
            m_idle = (bus.rd[owner] || bus.wr[owner]) ? 0 : m_idle + 1;
         end
      end
      req_prev = bus.req;
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
         if (sb.size() != 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            check("rvalid_overdue", e.due, cyc);
         end
         if (bus.rvalid != 8'h00) begin
            if (sb.size() == 0) begin
               check("rvalid_unexpected", {24'b0, bus.rvalid}, 0);
            end else begin
               e = sb.pop_front();
               check("rvalid_tag", {24'b0, bus.rvalid}, 32'd1 << e.tag);
               check("rdata", {24'b0, bus.rdata}, {24'b0, e.data});
               check("rd_latency", cyc, e.due);
            end
            for (int i = 0; i < 8; i++) if (bus.rvalid[i]) rv_count[i]++;
            rv_total++;
         end
      end
   end

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = '0;
      bus.rd  = '0;
      bus.wr  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      bus.req = '0;
      bus.rd  = '0;
      bus.wr  = '0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input string name, output int idx);
      idx = -1;
      for (int t = 0; t < 40 && idx < 0; t++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < 8; i++) if (bus.gnt[i]) idx = i;
      end
      check({name, "_grant_seen"}, idx >= 0, 1);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL global_timeout: got=running want=finished");
      $fatal(1, "bench time limit");
   end

   initial begin : stim
      int         idx;
      int         rv3, rvb, held;
      logic [7:0] r;
      bus.req       = '0;
      bus.rd        = '0;
      bus.wr        = '0;
      bus.mem_rdata = '0;
      for (int i = 0; i < 8; i++) rv_count[i] = 0;

      do_reset();
      check("rst_gnt",    {24'b0, bus.gnt}, 0);
      check("rst_select", {29'b0, bus.select}, 0);
      check("rst_mem_re", {31'b0, bus.mem_re}, 0);
      check("rst_mem_we", {31'b0, bus.mem_we}, 0);
      check("rst_rdata",  {24'b0, bus.rdata}, 0);
      check("rst_rvalid", {24'b0, bus.rvalid}, 0);
      check("rst_timeout", {31'b0, bus.timeout}, 0);

      // single owner, three back-to-back reads with known data
      bus.req = 8'h01;
      @(posedge clk);
      #1;
      check("grant_latency_gnt", {24'b0, bus.gnt}, 32'h01);
      check("grant_latency_sel", {29'b0, bus.select}, 0);
      for (int i = 0; i < 3; i++) begin
         bus.rd    = 8'h01;
         use_fixed = 1'b1;
         fixed_val = 8'hA1 + 8'(i);
         @(posedge clk);
         #1;
      end
      bus.rd    = '0;
      use_fixed = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("burst_rvalid0_count", rv_count[0], 3);
      idle_cycles(3);

      // full round-robin sweep from a fresh reset
      do_reset();
      bus.req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         wait_gnt("rr_seq", idx);
         check("rr_order", idx, k % 8);
         if (idx < 0) break;
         bus.wr = 8'd1 << idx;
         @(posedge clk);
         #1;
         bus.wr       = '0;
         bus.req[idx] = 1'b0;
         @(posedge clk);
         #1;
         check("rr_gap_cycle", {24'b0, bus.gnt}, 0);
         bus.req[idx] = 1'b1;
      end
      idle_cycles(4);

      // owner reads then leaves at once; next owner waits for the return
      bus.req = 8'h08;
      wait_gnt("drain_owner", idx);
      check("drain_owner_idx", idx, 3);
      rv3     = rv_count[3];
      bus.rd  = 8'h08;
      bus.req = 8'h28;
      @(posedge clk);
      #1;
      bus.rd  = '0;
      bus.req = 8'h20;
      wait_gnt("drain_next", idx);
      check("drain_next_gnt", {24'b0, bus.gnt}, 32'h20);
      check("drain_rvalid3_before", rv_count[3], rv3 + 1);
      idle_cycles(4);

      // non-owner strobes are ignored
      bus.req = 8'h04;
      wait_gnt("nonowner", idx);
      for (int k = 0; k < 4; k++) begin
         bus.rd = T_RD[k];
         bus.wr = T_WR[k];
         #2;
         check("nonowner_mem_re", {31'b0, bus.mem_re}, {31'b0, T_RE[k]});
         check("nonowner_mem_we", {31'b0, bus.mem_we}, {31'b0, T_WE[k]});
         @(posedge clk);
         #1;
      end
      idle_cycles(6);
      check("nonowner_no_rvalid6", rv_count[6], 0);

      // reset while a read is in flight
      bus.req = 8'h01;
      wait_gnt("rst_mid", idx);
      bus.rd = 8'h01;
      @(posedge clk);
      #1;
      bus.rd  = '0;
      bus.req = '0;
      rst     = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rvb = rv_total;
      repeat (6) @(posedge clk);
      #1;
      check("rst_mid_no_rvalid", rv_total, rvb);
      bus.req = 8'h90;
      wait_gnt("rst_restart", idx);
      check("rst_restart_idx", idx, 4);
      idle_cycles(4);

      // randomised traffic
      r = '0;
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < 8; i++) begin
            if (r[i]) begin
               if ($urandom_range(0, 9) == 0) r[i] = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
               r[i] = 1'b1;
            end
         end
         bus.req = r;
         bus.rd  = 8'($urandom) & 8'($urandom);
         bus.wr  = 8'($urandom) & 8'($urandom);
         @(posedge clk);
         #1;
      end
      idle_cycles(12);
      check("random_all_returned", sb.size(), 0);
      check("random_gnt_released", {24'b0, bus.gnt}, 0);

`ifdef ARB_TIMEOUT_EN
      bus.req = 8'h02;
      wait_gnt("to_owner", idx);
      held = 1;
      while (bus.gnt != 8'h00 && held < 300) begin
         @(posedge clk);
         #1;
         if (bus.gnt != 8'h00) held++;
      end
      check("to_hold_cycles", held, 256);
      check("to_flag_set", {31'b0, bus.timeout}, 1);
      repeat (5) @(posedge clk);
      #1;
      check("to_flag_sticky", {31'b0, bus.timeout}, 1);
      do_reset();
      check("to_flag_cleared", {31'b0, bus.timeout}, 0);
`else
      bus.req = 8'h02;
      wait_gnt("hold_owner", idx);
      held = 0;
      repeat (300) begin
         @(posedge clk);
         #1;
         if (bus.gnt == 8'h02) held++;
      end
      check("hold_indefinitely", held, 300);
      check("no_timeout_flag", {31'b0, bus.timeout}, 0);
      idle_cycles(4);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
